// File: rtl/i2c_slave.sv
// I2C target: oversamples SCL/SDA on clk, decodes START/STOP, ACKs SLAVE_ADDR,
// hands written bytes to local logic and serves read bytes from tx_data.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
    logic                   scl_hist_reg, sda_hist_reg;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       rw_reg, rw_next;
    logic       ack_ok_reg, ack_ok_next;
    logic       done_reg, done_next;
    logic       busy_reg, busy_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_ack_reg, tx_ack_next;

    // Synchronizers reset to 1 so an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i2c_scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i2c_sda};
            scl_hist_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_hist_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_reg;
    assign scl_fall  = ~scl_s & scl_hist_reg;
    assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
    assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            rx_data_reg  <= 8'd0;
            sda_oe_reg   <= 1'b0;
            rw_reg       <= 1'b0;
            ack_ok_reg   <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_ack_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            rx_data_reg  <= rx_data_next;
            sda_oe_reg   <= sda_oe_next;
            rw_reg       <= rw_next;
            ack_ok_reg   <= ack_ok_next;
            done_reg     <= done_next;
            busy_reg     <= busy_next;
            rx_valid_reg <= rx_valid_next;
            tx_ack_reg   <= tx_ack_next;
        end
    end

    // done_reg marks "byte (or address) complete, act on the next SCL fall".
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        rx_data_next  = rx_data_reg;
        sda_oe_next   = sda_oe_reg;
        rw_next       = rw_reg;
        ack_ok_next   = ack_ok_reg;
        done_next     = done_reg;
        busy_next     = busy_reg;
        rx_valid_next = 1'b0;
        tx_ack_next   = 1'b0;

        if (stop_det) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
            done_next   = 1'b0;
        end else if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 3'd7;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b0;
        end else begin
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        shift_next = {shift_reg[6:0], sda_s};
                        if (bit_cnt_reg == 3'd0) begin
                            if (shift_next[7:1] == SLAVE_ADDR) begin
                                rw_next   = shift_next[0];
                                busy_next = 1'b1;
                                done_next = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 3'd1;
                        end
                    end else if (scl_fall && done_reg) begin
                        sda_oe_next = 1'b1;
                        done_next   = 1'b0;
                        state_next  = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 3'd7;
                        if (rw_reg) begin
                            shift_next  = tx_data;
                            tx_ack_next = 1'b1;
                            sda_oe_next = ~tx_data[7];
                            state_next  = READ;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_next = {shift_reg[6:0], sda_s};
                        if (bit_cnt_reg == 3'd0) begin
                            rx_data_next  = shift_next;
                            rx_valid_next = rx_ready;
                            ack_ok_next   = rx_ready;
                            done_next     = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 3'd1;
                        end
                    end else if (scl_fall && done_reg) begin
                        sda_oe_next = ack_ok_reg;
                        done_next   = 1'b0;
                        state_next  = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 3'd7;
                        state_next   = ack_ok_reg ? WRITE : WAIT_STOP;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        if (bit_cnt_reg == 3'd0) done_next = 1'b1;
                        else                     bit_cnt_next = bit_cnt_reg - 3'd1;
                    end else if (scl_fall) begin
                        if (done_reg) begin
                            sda_oe_next = 1'b0;
                            done_next   = 1'b0;
                            state_next  = READ_ACK;
                        end else begin
                            shift_next  = {shift_reg[6:0], 1'b0};
                            sda_oe_next = ~shift_reg[6];
                        end
                    end
                end
                READ_ACK: begin
                    // A NACK leaves at the rise; only an ACKed byte reaches the fall.
                    if (scl_rise && sda_s) begin
                        state_next = WAIT_STOP;
                    end else if (scl_fall) begin
                        shift_next   = tx_data;
                        tx_ack_next  = 1'b1;
                        sda_oe_next  = ~tx_data[7];
                        bit_cnt_next = 3'd7;
                        state_next   = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda  = sda_oe_reg ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_ack   = tx_ack_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master with random transactions, checked
// against a transaction-level model of which bytes are ACKed, delivered and returned.
module tb_i2c_slave;

    localparam int Q = 8;
    localparam logic [6:0] OWN_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ack, busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(OWN_ADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .i2c_scl  (scl),
        .i2c_sda  (sda_bus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Bus monitor: logs delivered bytes and counts pulses / stray activity.
    logic [7:0] rx_log [256];
    int rx_total = 0, tx_ack_total = 0, both_hi = 0, busy_cycles = 0, drive_cycles = 0;
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_total < 256) rx_log[rx_total] <= rx_data;
            rx_total <= rx_total + 1;
        end
        if (tx_ack) tx_ack_total <= tx_ack_total + 1;
        if (rx_valid && tx_ack) both_hi <= both_hi + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (sda_bus === 1'b0 && !m_sda_low) drive_cycles <= drive_cycles + 1;
    end

    // Local read source: the k-th tx_ack of a read consumes rd_bytes[k].
    logic [7:0] rd_bytes [8];
    int tx_base = 0;
    always_comb begin
        tx_data = 8'h00;
        if ((tx_ack_total - tx_base) >= 0 && (tx_ack_total - tx_base) < 8)
            tx_data = rd_bytes[tx_ack_total - tx_base];
    end

    logic [7:0] wr_bytes [4];
    logic       wr_ready [4];

    task automatic hold();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        m_sda_low = ~b;
        hold();
        scl = 1'b1;
        hold();
        seen = sda_bus;
        hold();
        scl = 1'b0;
        hold();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        hold();
        scl = 1'b1;
        hold();
        m_sda_low = 1'b1;
        hold();
        scl = 1'b0;
        hold();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        hold();
        scl = 1'b1;
        hold();
        m_sda_low = 1'b0;
        hold();
        hold();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d, output logic ack_seen);
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(nack, ack_seen);
    endtask

    task automatic do_write(input logic [6:0] a, input int n);
        int rx0 = rx_total, busy0 = busy_cycles, drv0 = drive_cycles;
        logic match = (a == OWN_ADDR);
        logic nacked = 1'b0;
        logic ack, exp_ack;
        logic [7:0] exp_q[$];
        i2c_start();
        send_byte({a, 1'b0}, ack);
        check_val($sformatf("wr addr 0x%02h ack", a), ack, !match);
        check_val("wr busy after addr", busy, match);
        for (int i = 0; i < n; i++) begin
            rx_ready = wr_ready[i];
            if (!match || nacked) exp_ack = 1'b1;
            else if (wr_ready[i]) begin exp_ack = 1'b0; exp_q.push_back(wr_bytes[i]); end
            else begin exp_ack = 1'b1; nacked = 1'b1; end
            send_byte(wr_bytes[i], ack);
            check_val($sformatf("wr byte %0d (0x%02h) ack", i, wr_bytes[i]), ack, exp_ack);
        end
        i2c_stop();
        rx_ready = 1'b1;
        check_val("wr busy after stop", busy, 0);
        check_val("wr rx_valid count", rx_total - rx0, exp_q.size());
        for (int k = 0; k < exp_q.size() && (rx0 + k) < 256; k++)
            check_val($sformatf("wr rx_data %0d", k), rx_log[rx0 + k], exp_q[k]);
        if (!match) begin
            check_val("wr foreign busy cycles", busy_cycles - busy0, 0);
            check_val("wr foreign sda driven", drive_cycles - drv0, 0);
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n, input logic rstart);
        int tx0 = tx_ack_total, rx0 = rx_total;
        logic match = (a == OWN_ADDR);
        logic ack;
        logic [7:0] got;
        tx_base = tx_ack_total;
        if (rstart) begin
            i2c_start();
            send_byte({OWN_ADDR, 1'b0}, ack);
            check_val("rs write addr ack", ack, 0);
        end
        i2c_start();
        send_byte({a, 1'b1}, ack);
        check_val($sformatf("rd addr 0x%02h ack", a), ack, !match);
        check_val("rd busy after addr", busy, match);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, got, ack);
                check_val($sformatf("rd byte %0d", i), got, rd_bytes[i]);
                if (i == n - 1) check_val("rd nack bit released", ack, 1);
            end
        end
        i2c_stop();
        check_val("rd tx_ack count", tx_ack_total - tx0, match ? n : 0);
        check_val("rd no rx_valid", rx_total - rx0, 0);
        check_val("rd busy after stop", busy, 0);
    endtask

    initial begin
        logic ack, s;
        logic [6:0] a;
        int n;

        repeat (5) @(negedge clk);
        check_val("reset rx_data", rx_data, 0);
        check_val("reset rx_valid", rx_valid, 0);
        check_val("reset tx_ack", tx_ack, 0);
        check_val("reset busy", busy, 0);
        check_val("reset sda released", sda_bus, 1);
        reset = 1'b1;
        hold();

        // Directed: single write, foreign address, two-byte read, NACK write.
        wr_bytes[0] = 8'hA5; wr_ready[0] = 1'b1;
        do_write(7'h50, 1);
        do_write(7'h51, 1);
        rd_bytes[0] = 8'h3C; rd_bytes[1] = 8'hC3;
        do_read(7'h50, 2, 1'b0);
        wr_bytes[0] = 8'h11; wr_ready[0] = 1'b1;
        wr_bytes[1] = 8'h22; wr_ready[1] = 1'b0;
        wr_bytes[2] = 8'h33; wr_ready[2] = 1'b1;
        do_write(7'h50, 3);

        // Repeated START: write address, then read without STOP.
        rd_bytes[0] = 8'h96;
        do_read(7'h50, 1, 1'b1);

        // Random traffic.
        for (int t = 0; t < 10; t++) begin
            a = OWN_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == OWN_ADDR) a = 7'h51;
            end
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    wr_bytes[i] = 8'($urandom);
                    wr_ready[i] = ($urandom_range(0, 4) != 0);
                end
                do_write(a, n);
            end else begin
                for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
                do_read(a, n, 1'b0);
            end
        end

        // Reset while the target drives a 0 data bit of a read.
        rd_bytes[0] = 8'h00;
        tx_base = tx_ack_total;
        i2c_start();
        send_byte({OWN_ADDR, 1'b1}, ack);
        check_val("rst rd addr ack", ack, 0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
        m_sda_low = 1'b0;
        hold();
        check_val("rst sda driven before reset", sda_bus, 0);
        reset = 1'b0;
        #1;
        check_val("rst sda released", sda_bus, 1);
        check_val("rst busy", busy, 0);
        check_val("rst rx_data", rx_data, 0);
        check_val("rst rx_valid", rx_valid, 0);
        check_val("rst tx_ack", tx_ack, 0);
        hold();
        reset = 1'b1;
        hold();
        i2c_stop();
        wr_bytes[0] = 8'h5A; wr_ready[0] = 1'b1;
        do_write(7'h50, 1);

        check_val("rx_valid and tx_ack overlap", both_hi, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) that sits directly downstream of the bus master and consumes its i2c_scl/i2c_sda.
- Oversamples the bus on a local system clock and detects START and STOP conditions.
- Matches a 7-bit address and ACKs it; delivers written bytes to local logic and serves read bytes from local logic.
- SDA is open-drain: the block only ever pulls it low or releases it.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target answers to
SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2)

Ports:
clk  input  1  system clock; each SCL high and low phase must last at least 4 clk cycles
reset  input  1  asynchronous, active-low reset
i2c_scl  input  1  bus clock from master
i2c_sda  inout  1  bus data; driven 0 when sda_oe=1, otherwise 'z
rx_data  output  8  last byte written by master
rx_valid  output  1  one-cycle pulse, rx_data updated
rx_ready  input  1  local sink can accept a byte; sampled at the 8th data bit
tx_data  input  8  byte to return on a master read
tx_ack  output  1  one-cycle pulse, tx_data has been loaded
busy  output  1  high from address match until STOP or repeated START

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, sda_oe=0 (SDA released), rx_data=0, rx_valid=0, tx_ack=0, busy=0, bit counter=0. Reset mid-transfer releases SDA immediately.
- Input sampling: SCL and SDA pass through SYNC_STAGES flops plus one history flop; bus-to-detect latency is SYNC_STAGES+1 clk.
- Bus events (from synchronized samples):
  - SCL rise/fall = edge of the synchronized SCL.
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
- Timing rules: data is sampled on SCL rise; sda_oe changes only on SCL fall (same clk as fall detect).
- START from any state (repeated START included): -> ADDR, bit counter=7, sda_oe=0, busy=0.
- STOP from any state: -> IDLE, sda_oe=0, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first ([7:1] address, [0] rw). On the 8th rise, compare [7:1] with SLAVE_ADDR.
    - Mismatch: -> IDLE; never drive SDA.
    - Match: latch rw, busy=1. At the next fall, sda_oe=1 -> ADDR_ACK.
  - ADDR_ACK: hold SDA low through the ACK clock. At its fall:
    - rw=0: sda_oe=0 -> WRITE, counter=7.
    - rw=1: load shift register from tx_data, pulse tx_ack, drive bit7 (sda_oe = ~tx_data[7]) -> READ, counter=7.
  - WRITE: shift on each rise. On the 8th rise:
    - rx_data <= byte.
    - rx_valid pulses for 1 clk if rx_ready=1.
    - Remember ack_ok = rx_ready.
    - At the next fall: sda_oe=ack_ok -> WRITE_ACK.
  - WRITE_ACK: at the fall ending the ACK bit, sda_oe=0.
    - ack_ok=1: -> WRITE, counter=7.
    - ack_ok=0 (NACK; byte dropped, rx_valid not pulsed): -> WAIT_STOP.
  - READ: at each fall after a bit, present the next bit (sda_oe = ~bit). At the fall after the 8th bit, sda_oe=0 -> READ_ACK.
  - READ_ACK: sample master SDA on the rise.
    - 0 (ACK): at the next fall, load tx_data, pulse tx_ack, drive bit7 -> READ.
    - 1 (NACK): -> WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bits; leave only on STOP or START.
- Counter: 3-bit, decrements on each rise in ADDR/WRITE/READ; byte completes when 0 is sampled; no wrap beyond one byte.
- Simultaneous events: START/STOP detection has priority over any bit sample in the same clk. An SCL edge and an SDA change never coincide after synchronization, as the master holds SDA stable around SCL edges.
- rx_valid and tx_ack are never high in the same clk.

Test Plan:
- Write to SLAVE_ADDR 0x50 with byte 0xA5, rx_ready=1 -> SDA low during both ACK bits; rx_data=0xA5; exactly one rx_valid pulse; busy=1 until STOP, then 0.
- Address 0x51 write -> SDA never driven (sda_oe=0 for the whole frame); busy stays 0; no rx_valid.
- Read from 0x50, tx_data=0x3C, master ACKs the first byte and NACKs the second (tx_data=0xC3) -> bus carries 0x3C then 0xC3 MSB first; two tx_ack pulses; SDA released after the NACK.
- Write 0x11, 0x22 with rx_ready=0 on the second byte -> first byte ACKed with rx_valid; second byte NACKed (SDA high on its ACK bit), no rx_valid; state WAIT_STOP until STOP.
- Repeated START after the write address ACK, then read address 0x50 -> counter restarts; tx_ack pulses; read proceeds with no STOP in between.
- Assert reset mid-way through the READ data phase -> SDA released (sda_oe=0) asynchronously; all outputs 0. After reset deasserts, a new START plus address 0x50 is ACKed normally.
